// File: rtl/config_loader.sv
// config_loader: clears a downstream LUT config chain, then shifts a word-wide
// bitstream into it one frame per cycle, returning the displaced frames as readback.
module config_loader #(
    parameter int unsigned FRAME_WIDTH  = 1,
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned CHAIN_FRAMES = 16
) (
    input  logic                   config_clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   chain_reset,
    output logic                   config_en,
    output logic [FRAME_WIDTH-1:0] config_in,
    input  logic [FRAME_WIDTH-1:0] config_return,
    output logic                   rb_valid,
    output logic [FRAME_WIDTH-1:0] rb_frame,
    output logic                   busy,
    output logic                   done
);

    // Frames per word, words per full chain, and counter widths.
    localparam int unsigned K   = WORD_WIDTH / FRAME_WIDTH;
    localparam int unsigned NW  = (CHAIN_FRAMES * FRAME_WIDTH) / WORD_WIDTH;
    localparam int unsigned CW  = $clog2(K + 1);
    localparam int unsigned FCW = $clog2(CHAIN_FRAMES + 1);
    localparam int unsigned WCW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WORD_WIDTH-1:0] r_shift;
    logic [WORD_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         r_cnt;        // frames of the current word still to shift
    logic [CW-1:0]         w_cnt_nxt;
    logic [FCW-1:0]        r_frames;     // frames shifted into the chain this load
    logic [FCW-1:0]        w_frames_nxt;
    logic [WCW-1:0]        r_words;      // words accepted this load
    logic [WCW-1:0]        w_words_nxt;

    logic                  r_in_ready;
    logic                  r_chain_reset;
    logic                  r_config_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_rb_valid;
    logic [FRAME_WIDTH-1:0] r_rb_frame;

    logic                  w_in_ready_nxt;
    logic                  w_chain_reset_nxt;
    logic                  w_config_en_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_accept;

    assign w_accept = in_valid && r_in_ready;

    // State register.
    always_ff @(posedge config_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, datapath next values and next registered outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_frames_nxt = r_frames;
        w_words_nxt  = r_words;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_state_nxt  = S_LOAD;
                w_shift_nxt  = '0;
                w_cnt_nxt    = '0;
                w_frames_nxt = '0;
                w_words_nxt  = '0;
            end
            S_LOAD: begin
                if (r_config_en) begin
                    w_shift_nxt  = r_shift << FRAME_WIDTH;
                    w_cnt_nxt    = r_cnt - CW'(1);
                    w_frames_nxt = r_frames + FCW'(1);
                    if (r_frames == FCW'(CHAIN_FRAMES - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
                // A word accepted on the last frame cycle replaces the drained buffer seamlessly.
                if (w_accept) begin
                    w_shift_nxt = in_data;
                    w_cnt_nxt   = CW'(K);
                    w_words_nxt = r_words + WCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt        = (w_state_nxt == S_CLEAR) || (w_state_nxt == S_LOAD);
        w_done_nxt        = (w_state_nxt == S_DONE);
        w_chain_reset_nxt = (w_state_nxt == S_CLEAR);
        w_config_en_nxt   = (w_state_nxt == S_LOAD) && (w_cnt_nxt != '0);
        w_in_ready_nxt    = (w_state_nxt == S_LOAD) && (w_cnt_nxt <= CW'(1))
                            && (w_words_nxt < WCW'(NW));
    end

    // Datapath and output registers.
    always_ff @(posedge config_clk or negedge reset) begin
        if (!reset) begin
            r_shift       <= '0;
            r_cnt         <= '0;
            r_frames      <= '0;
            r_words       <= '0;
            r_in_ready    <= 1'b0;
            r_chain_reset <= 1'b0;
            r_config_en   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_shift       <= w_shift_nxt;
            r_cnt         <= w_cnt_nxt;
            r_frames      <= w_frames_nxt;
            r_words       <= w_words_nxt;
            r_in_ready    <= w_in_ready_nxt;
            r_chain_reset <= w_chain_reset_nxt;
            r_config_en   <= w_config_en_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    // Capture the frame pushed out of the chain tail on every shift.
    always_ff @(posedge config_clk or negedge reset) begin
        if (!reset) begin
            r_rb_valid <= 1'b0;
            r_rb_frame <= '0;
        end else if (r_config_en) begin
            r_rb_valid <= 1'b1;
            r_rb_frame <= config_return;
        end else begin
            r_rb_valid <= 1'b0;
        end
    end

    assign in_ready    = r_in_ready;
    assign chain_reset = r_chain_reset;
    assign config_en   = r_config_en;
    assign config_in   = r_shift[WORD_WIDTH-1 -: FRAME_WIDTH];
    assign rb_valid    = r_rb_valid;
    assign rb_frame    = r_rb_frame;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: queue-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_config_loader;

    localparam int unsigned FW = 1;
    localparam int unsigned WW = 8;
    localparam int unsigned CF = 16;
    localparam int unsigned K  = WW / FW;
    localparam int unsigned NW = (CF * FW) / WW;

    logic          config_clk = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          chain_reset;
    logic          config_en;
    logic [FW-1:0] config_in;
    logic [FW-1:0] config_return;
    logic          rb_valid;
    logic [FW-1:0] rb_frame;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    config_loader #(
        .FRAME_WIDTH (FW),
        .WORD_WIDTH  (WW),
        .CHAIN_FRAMES(CF)
    ) dut (
        .config_clk   (config_clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .chain_reset  (chain_reset),
        .config_en    (config_en),
        .config_in    (config_in),
        .config_return(config_return),
        .rb_valid     (rb_valid),
        .rb_frame     (rb_frame),
        .busy         (busy),
        .done         (done)
    );

    always #5 config_clk = ~config_clk;

    // Downstream chain: a plain 16-frame shift register holding its config frames.
    logic [CF-1:0] chain = '0;
    always @(posedge config_clk) begin
        if (config_en) chain <= {chain[CF-2:0], config_in};
    end
    assign config_return = chain[CF-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 clear, 2 load, 3 done; frames pending in a queue.
    int   m_mode = 0;
    logic m_q[$];
    int   m_words = 0;
    int   m_frames = 0;
    logic m_rbv = 1'b0;
    logic m_rbf = 1'b0;
    logic e_en, e_ready, e_acc;
    logic [7:0] exp_v, act_v;

    logic tr_en[$];
    logic tr_done[$];
    logic tr_cr[$];
    logic tr_cfg[$];
    logic tr_rb[$];

    // Compare every cycle away from the active edge, then advance the model past the next edge.
    always @(negedge config_clk) begin
        if (!reset) begin
            m_mode = 0; m_q.delete(); m_words = 0; m_frames = 0; m_rbv = 1'b0; m_rbf = 1'b0;
        end
        e_en    = (m_mode == 2) && (m_q.size() > 0);
        e_ready = (m_mode == 2) && (m_q.size() <= 1) && (m_words < NW);
        exp_v = {e_ready, m_mode == 1, e_en, (e_en ? m_q[0] : 1'b0), m_rbv, m_rbf,
                 (m_mode == 1) || (m_mode == 2), m_mode == 3};
        act_v = {in_ready, chain_reset, config_en, config_in, rb_valid, rb_frame, busy, done};
        check("cycle", 32'(act_v), 32'(exp_v));

        tr_en.push_back(config_en);
        tr_done.push_back(done);
        tr_cr.push_back(chain_reset);
        if (config_en) tr_cfg.push_back(config_in);
        if (rb_valid) tr_rb.push_back(rb_frame);

        if (reset) begin
            e_acc = in_valid && e_ready;
            if (e_en) begin
                m_rbv = 1'b1;
                m_rbf = config_return;
                void'(m_q.pop_front());
                m_frames++;
            end else begin
                m_rbv = 1'b0;
            end
            if (e_acc) begin
                for (int i = 0; i < int'(K); i++) m_q.push_back(in_data[WW-1-i]);
                m_words++;
            end
            case (m_mode)
                0, 3: if (start) m_mode = 1;
                1: begin m_mode = 2; m_frames = 0; m_words = 0; m_q.delete(); end
                2: if (e_en && m_frames == int'(CF)) begin m_mode = 3; m_q.delete(); end
                default: m_mode = 0;
            endcase
        end
    end

    task automatic clr_traces();
        tr_en.delete(); tr_done.delete(); tr_cr.delete(); tr_cfg.delete(); tr_rb.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge config_clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [WW-1:0] d);
        logic ok;
        ok = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge config_clk);
            if (in_ready) ok = 1'b1;
        end
        check("send_timeout", 32'(ok), 32'd1);
        @(posedge config_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge config_clk);
            if (in_ready) ok = 1'b1;
        end
        check("ready_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge config_clk);
            if (done) ok = 1'b1;
        end
        check("done_timeout", 32'(ok), 32'd1);
        @(posedge config_clk); #1;
    endtask

    // Summarise the enable trace: count, span gap and done on the cycle after the last shift.
    task automatic check_run(input string tag, input int exp_ones, input int exp_gap);
        int ones, first, last;
        logic [15:0] seq;
        ones = 0; first = -1; last = -1; seq = '0;
        foreach (tr_en[i]) if (tr_en[i]) begin
            ones++;
            if (first < 0) first = i;
            last = i;
        end
        check({tag, "_en_count"}, 32'(ones), 32'(exp_ones));
        check({tag, "_en_gap"}, 32'(last - first + 1 - ones), 32'(exp_gap));
        if (last >= 0 && last + 1 < tr_done.size())
            check({tag, "_done_after"}, 32'({tr_done[last], tr_done[last+1]}), 32'b01);
        else
            check({tag, "_done_after"}, 32'(last), 32'hFFFF_FFFF);
        foreach (tr_cfg[i]) seq = {seq[14:0], tr_cfg[i]};
        check({tag, "_cfg_seq"}, 32'(seq), 32'h0000_A53C);
    endtask

    function automatic int count_ones(input logic q[$]);
        int c;
        c = 0;
        foreach (q[i]) if (q[i]) c++;
        return c;
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge config_clk); #1;
        check("reset_state",
              32'({in_ready, chain_reset, config_en, config_in, rb_valid, rb_frame, busy, done}), 32'd0);
        reset = 1'b1;
        @(posedge config_clk); #1;
        check("idle_after_reset", 32'({in_ready, busy, done}), 32'd0);

        // Back-to-back words: continuous 16 enables, one clear cycle.
        clr_traces();
        pulse_start();
        send_word(8'hA5);
        send_word(8'h3C);
        wait_done();
        repeat (2) @(posedge config_clk); #1;
        check_run("b2b", 16, 0);
        check("b2b_clear_cycles", 32'(count_ones(tr_cr)), 32'd1);

        // Three-cycle input stall between words.
        clr_traces();
        pulse_start();
        send_word(8'hA5);
        wait_ready();
        repeat (3) @(posedge config_clk); #1;
        send_word(8'h3C);
        wait_done();
        repeat (2) @(posedge config_clk); #1;
        check_run("stall", 16, 3);

        // Fill chain with ones, then load zeros and read back the displaced ones.
        pulse_start();
        send_word(8'hFF);
        send_word(8'hFF);
        wait_done();
        clr_traces();
        pulse_start();
        send_word(8'h00);
        send_word(8'h00);
        wait_done();
        repeat (2) @(posedge config_clk); #1;
        check("rb_count", 32'(tr_rb.size()), 32'd16);
        check("rb_ones", 32'(count_ones(tr_rb)), 32'd16);

        // Reset after five frames abandons the load.
        clr_traces();
        pulse_start();
        send_word(8'h5A);
        repeat (5) @(posedge config_clk); #1;
        check("frames_before_rst", 32'(count_ones(tr_en)), 32'd5);
        check("en_before_rst", 32'(config_en), 32'd1);
        reset = 1'b0;
        #1;
        check("async_rst_outputs",
              32'({in_ready, chain_reset, config_en, config_in, rb_valid, rb_frame, busy, done}), 32'd0);
        @(posedge config_clk); #1;
        reset = 1'b1;
        @(negedge config_clk);
        check("post_rst_idle", 32'({in_ready, busy, done, config_en}), 32'd0);
        repeat (3) @(posedge config_clk); #1;
        check("post_rst_stays_idle", 32'({in_ready, busy, done, chain_reset}), 32'd0);

        // Start during LOAD ignored; extra word in DONE left unaccepted.
        clr_traces();
        pulse_start();
        send_word(8'hA5);
        pulse_start();
        send_word(8'h3C);
        wait_done();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (6) begin
            @(negedge config_clk);
            check("done_refuses_word", 32'({in_ready, done, config_en}), 32'b010);
        end
        @(posedge config_clk); #1;
        in_valid = 1'b0;
        check_run("ignore", 16, 0);
        check("ignore_clear_cycles", 32'(count_ones(tr_cr)), 32'd1);

        // Start in DONE begins a fresh clear.
        pulse_start();
        check("restart_clear", 32'({chain_reset, done, busy}), 32'b101);
        send_word(8'hC3);
        send_word(8'h81);
        wait_done();
        check("restart_done", 32'({done, busy}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/config_loader.md
CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 1, bits per config frame (matches LUT chain frame width).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, bits per input word; WORD_WIDTH is a multiple of FRAME_WIDTH.
REQ-003 SHALL have parameter CHAIN_FRAMES, default 16, total frames in the downstream chain; CHAIN_FRAMES*FRAME_WIDTH is a multiple of WORD_WIDTH.
REQ-004 SHALL have port config_clk  in  1  sole clock; it also clocks the downstream chain.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  single-cycle request to begin a load.
REQ-007 SHALL have port in_data  in  WORD_WIDTH  bitstream word.
REQ-008 SHALL have port in_valid  in  1  in_data is valid.
REQ-009 SHALL have port in_ready  out  1  loader accepts in_data this cycle.
REQ-010 SHALL have port chain_reset  out  1  synchronous clear to the chain.
REQ-011 SHALL have port config_en  out  1  chain shift enable.
REQ-012 SHALL have port config_in  out  FRAME_WIDTH  frame into the chain head.
REQ-013 SHALL have port config_return  in  FRAME_WIDTH  frame from the chain tail.
REQ-014 SHALL have port rb_valid, rb_frame  out  1, FRAME_WIDTH  readback of displaced frames.
REQ-015 SHALL have port busy, done  out  1 each  status.

Function
REQ-016 SHALL implement states IDLE, CLEAR, LOAD, DONE.
REQ-017 SHALL move IDLE->CLEAR or DONE->CLEAR on start; start SHALL be ignored in CLEAR and LOAD.
REQ-018 SHALL assert chain_reset for exactly the one CLEAR cycle, then enter LOAD with frame and word counters zeroed.
REQ-019 SHALL accept a word when in_valid && in_ready; in_ready = LOAD && buffered frames <= 1 && words accepted < CHAIN_FRAMES*FRAME_WIDTH/WORD_WIDTH.
REQ-020 SHALL, on acceptance at edge t, drive config_en=1 for the next K=WORD_WIDTH/FRAME_WIDTH cycles, with config_in carrying the word MSB frame first.
REQ-021 SHALL, when a word is accepted in the last frame cycle of the previous word, shift with no bubble (back-to-back stream gives continuous config_en).
REQ-022 SHALL hold config_en=0 when the buffer is empty; in_valid stalls SHALL create bubbles and never corrupt frame order.
REQ-023 SHALL increment the frame counter on every cycle with config_en=1; on the edge shifting frame CHAIN_FRAMES it SHALL enter DONE.
REQ-024 SHALL, at each edge where config_en=1, register rb_frame <= config_return and rb_valid <= 1; otherwise rb_valid <= 0.
REQ-025 SHALL drive busy=1 in CLEAR and LOAD, done=1 only in DONE (held until next start).
REQ-026 SHALL drive config_en, in_ready, chain_reset all 0 in IDLE and DONE; excess in_valid in DONE SHALL be left unaccepted.
REQ-027 SHALL drive all outputs from registers or from state/counter registers only, with no combinational path from in_valid to config_en.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, counters and buffer 0, and all outputs 0 (config_in=0, rb_frame=0).
REQ-029 SHALL abandon a load on reset mid-operation without further config_en pulses; the chain is not cleared until the next CLEAR.
REQ-030 SHALL resume on the first config_clk edge after reset deasserts, remaining in IDLE until start.

Verification (FRAME_WIDTH=1, WORD_WIDTH=8, CHAIN_FRAMES=16)
REQ-031 SHALL cover: start, then words 0xA5,0x3C back-to-back -> chain_reset 1 cycle; config_en high 16 consecutive cycles; config_in = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0; done=1 the cycle after.
REQ-032 SHALL cover: in_valid dropped 3 cycles between the two words -> exactly a 3-cycle gap in config_en, identical frame sequence, done after 16 enables.
REQ-033 SHALL cover: chain preloaded with 16 ones, new load of 0x00,0x00 -> rb_valid 16 cycles, rb_frame all 1 (readback of displaced contents).
REQ-034 SHALL cover: reset pulled low after 5 frames -> all outputs 0 asynchronously; after release, IDLE, in_ready=0, busy=0.
REQ-035 SHALL cover: start asserted during LOAD and a third word offered in DONE -> both ignored; in_ready=0; done stays 1 until next start.
REQ-036 SHALL cover: start in DONE -> new CLEAR with chain_reset=1, done=0, busy=1 the next cycle.
